seq_divider_32: RTL and testbench



---
 rtl/seq_divider_32.sv | 134 +++++++++++++
 tb/tb_seq_divider_32.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// Iterative restoring divider for MIPS DIV/DIVU: one trial subtraction per clock,
// producing quotient (LO) and remainder (HI) after WIDTH steps plus a sign-fix step.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             q_sign_q;
    logic             r_sign_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    // The shifted partial remainder can reach WIDTH+1 bits, so the trial keeps an
    // extra sign bit; a clear top bit means the subtraction did not borrow.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvsr_q};
        if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        abs_dividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_divisor  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            q_sign_q      <= 1'b0;
            r_sign_q      <= 1'b0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Keep the raw dividend in the quotient register; it becomes HI.
                            dz_q     <= 1'b1;
                            quo_q    <= dividend;
                            q_sign_q <= 1'b0;
                            r_sign_q <= 1'b0;
                            state_q  <= FIX;
                        end else begin
                            dz_q     <= 1'b0;
                            q_sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_sign_q <= is_signed & dividend[WIDTH-1];
                            quo_q    <= abs_dividend;
                            dvsr_q   <= abs_divisor;
                            rem_q    <= '0;
                            count_q  <= CNT_W'(WIDTH);
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dz_q) begin
                        quotient_q  <= '1;
                        remainder_q <= quo_q;
                    end else begin
                        quotient_q  <= q_sign_q ? -quo_q : quo_q;
                        remainder_q <= r_sign_q ? -rem_q : rem_q;
                    end
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: reset, unsigned/signed results, divide by zero,
// abort by reset, and back-to-back operation with hand-computed expectations.
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Issues one request and waits (bounded) for done, sampling 1ns after each edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output int lat, output int busy_cycles, output int overlap);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        overlap     = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
            if (busy && done) overlap++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (quotient !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_quotient: got %h expected 0", quotient); end
        n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_remainder: got %h expected 0", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dz: got %b expected 0", div_by_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu_basic();
        int lat, bc, ov;
        run_op(32'd100, 32'd7, 1'b0, lat, bc, ov);
        n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("[TB] FAIL divu_q: got %h expected %h", quotient, 32'd14); end
        n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("[TB] FAIL divu_r: got %h expected %h", remainder, 32'd2); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL divu_dz: got %b expected 0", div_by_zero); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL divu_latency: got %0d expected 33", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("[TB] FAIL divu_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (ov !== 0) begin n_fail++; $display("[TB] FAIL divu_busy_done_overlap: got %0d expected 0", ov); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL divu_done_pulse: got %b expected 0", done); end
        n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("[TB] FAIL divu_q_hold: got %h expected %h", quotient, 32'd14); end
    endtask

    task automatic test_signed();
        logic [31:0] va[5];
        logic [31:0] vb[5];
        logic        vs[5];
        logic [31:0] vq[5];
        logic [31:0] vr[5];
        int lat, bc, ov;
        va = '{32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9};
        vb = '{32'd2,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFF, 32'd2};
        vs = '{1'b1,          1'b1,          1'b0,          1'b1,          1'b0};
        vq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFC};
        vr = '{32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         32'd1};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vs[i], lat, bc, ov);
            n_checks++;
            if (quotient !== vq[i]) begin n_fail++; $display("[TB] FAIL signed_q[%0d]: got %h expected %h", i, quotient, vq[i]); end
            n_checks++;
            if (remainder !== vr[i]) begin n_fail++; $display("[TB] FAIL signed_r[%0d]: got %h expected %h", i, remainder, vr[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc, ov;
        run_op(32'd5, 32'd0, 1'b0, lat, bc, ov);
        n_checks++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL dz_q: got %h expected ffffffff", quotient); end
        n_checks++; if (remainder !== 32'd5) begin n_fail++; $display("[TB] FAIL dz_r: got %h expected 5", remainder); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("[TB] FAIL dz_flag: got %b expected 1", div_by_zero); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL dz_latency: got %0d expected 1", lat); end
        run_op(32'd9, 32'd3, 1'b0, lat, bc, ov);
        n_checks++; if (quotient !== 32'd3) begin n_fail++; $display("[TB] FAIL dz_next_q: got %h expected 3", quotient); end
        n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("[TB] FAIL dz_next_r: got %h expected 0", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL dz_clear: got %b expected 0", div_by_zero); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL dz_next_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_abort();
        int seen = 0;
        int lat, bc, ov;
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            start = (i == 10);
            if (i == 10) begin
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            if (done) seen++;
        end
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("[TB] FAIL abort_q_zero: got %h expected 0", quotient); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL abort_no_done: got %0d activity cycles expected 0", seen); end
        run_op(32'd50, 32'd5, 1'b0, lat, bc, ov);
        n_checks++; if (quotient !== 32'd10) begin n_fail++; $display("[TB] FAIL abort_new_q: got %h expected a", quotient); end
        n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("[TB] FAIL abort_new_r: got %h expected 0", remainder); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL abort_new_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, ov;
        int unstable = 0;
        run_op(32'd1000, 32'd7, 1'b0, lat, bc, ov);
        n_checks++; if (quotient !== 32'd142) begin n_fail++; $display("[TB] FAIL b2b_first_q: got %h expected %h", quotient, 32'd142); end
        dividend  = 32'd81;
        divisor   = 32'd9;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
        lat = 0;
        while (!done && lat < 100) begin
            if (quotient !== 32'd142 || remainder !== 32'd6) unstable++;
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("[TB] FAIL b2b_hold: got %0d changed cycles expected 0", unstable); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d expected 33", lat); end
        n_checks++; if (quotient !== 32'd9) begin n_fail++; $display("[TB] FAIL b2b_second_q: got %h expected 9", quotient); end
        n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("[TB] FAIL b2b_second_r: got %h expected 0", remainder); end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0;
        divisor   = 32'h0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_by_zero();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
